// File: rtl/ex_mem.sv
// EX/MEM pipeline register. It carries EX results toward MEM and inserts bubbles.
// It feeds the multi-cycle accumulate state back to EX while EX is stalled.
module ex_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_valid,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o,
    output logic [SCNT_W-1:0]   stall_cnt
);

    logic [ADDR_W-1:0]   mem_wd_q, mem_wd_d;
    logic                mem_wreg_q, mem_wreg_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_whilo_q, mem_whilo_d;
    logic [DATA_W-1:0]   mem_hi_q, mem_hi_d;
    logic [DATA_W-1:0]   mem_lo_q, mem_lo_d;
    logic                mem_valid_q, mem_valid_d;
    logic [2*DATA_W-1:0] hilo_q, hilo_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [SCNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_whilo_d = mem_whilo_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        mem_valid_d = mem_valid_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            mem_valid_d = 1'b0;
            hilo_d      = '0;
            cnt_d       = '0;
        end else if (stall[3] && !stall[4]) begin
            // EX held but MEM free: send a bubble and keep the accumulate state looping
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            mem_valid_d = 1'b0;
            hilo_d      = hilo_i;
            cnt_d       = cnt_i;
            if (stall_cnt_q != {SCNT_W{1'b1}})
                stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (!stall[3]) begin
            // stall[4] alone is illegal from ctrl and falls through to advance
            mem_wd_d    = ex_wd;
            mem_wreg_d  = ex_wreg;
            mem_wdata_d = ex_wdata;
            mem_whilo_d = ex_whilo;
            mem_hi_d    = ex_hi;
            mem_lo_d    = ex_lo;
            mem_valid_d = 1'b1;
            hilo_d      = '0;
            cnt_d       = '0;
        end else begin
            hilo_d = hilo_i;
            cnt_d  = cnt_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd_q    <= '0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_whilo_q <= 1'b0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
            mem_valid_q <= 1'b0;
            hilo_q      <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            mem_wd_q    <= mem_wd_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_whilo_q <= mem_whilo_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
            mem_valid_q <= mem_valid_d;
            hilo_q      <= hilo_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_wd    = mem_wd_q;
    assign mem_wreg  = mem_wreg_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_whilo = mem_whilo_q;
    assign mem_hi    = mem_hi_q;
    assign mem_lo    = mem_lo_q;
    assign mem_valid = mem_valid_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed scenarios plus random traffic against a rule-level reference model.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi, ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic        mem_valid;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad = 0;

    // reference state
    logic [4:0]  e_wd;
    logic        e_wreg, e_whilo, e_valid;
    logic [31:0] e_wdata, e_hi, e_lo;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
    int          e_scnt;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
        .hilo_o(hilo_o), .cnt_o(cnt_o), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_wd = 0; e_wreg = 0; e_wdata = 0; e_whilo = 0; e_hi = 0; e_lo = 0;
        e_valid = 0; e_hilo = 0; e_cnt = 0; e_scnt = 0;
    endtask

    task automatic model_clear_mem();
        e_wd = 0; e_wreg = 0; e_wdata = 0; e_whilo = 0; e_hi = 0; e_lo = 0; e_valid = 0;
    endtask

    // One clock edge as described by the rules: flush > bubble > advance > hold.
    task automatic model_edge();
        if (flush) begin
            model_clear_mem();
            e_hilo = 0; e_cnt = 0;
        end else if (!stall[3]) begin
            e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata; e_whilo = ex_whilo;
            e_hi = ex_hi; e_lo = ex_lo; e_valid = 1;
            e_hilo = 0; e_cnt = 0;
        end else if (!stall[4]) begin
            model_clear_mem();
            e_hilo = hilo_i; e_cnt = cnt_i;
            e_scnt = (e_scnt >= 65535) ? 65535 : e_scnt + 1;
        end else begin
            e_hilo = hilo_i; e_cnt = cnt_i;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".mem_wd"}, 64'(mem_wd), 64'(e_wd));
        chk({ph, ".mem_wreg"}, 64'(mem_wreg), 64'(e_wreg));
        chk({ph, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
        chk({ph, ".mem_whilo"}, 64'(mem_whilo), 64'(e_whilo));
        chk({ph, ".mem_hi"}, 64'(mem_hi), 64'(e_hi));
        chk({ph, ".mem_lo"}, 64'(mem_lo), 64'(e_lo));
        chk({ph, ".mem_valid"}, 64'(mem_valid), 64'(e_valid));
        chk({ph, ".hilo_o"}, hilo_o, e_hilo);
        chk({ph, ".cnt_o"}, 64'(cnt_o), 64'(e_cnt));
        chk({ph, ".stall_cnt"}, 64'(stall_cnt), 64'(e_scnt));
    endtask

    // Inputs are set between edges; model and DUT both see them at the next rising edge.
    task automatic tick(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_whilo = 1'b1; ex_hi = ~wdata; ex_lo = wdata ^ 32'h5A5A_5A5A;
    endtask

    initial begin
        rst = 1'b0; stall = 0; flush = 0;
        set_ex(0, 0, 0); ex_whilo = 0; ex_hi = 0; ex_lo = 0;
        hilo_i = 0; cnt_i = 0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #3;
        rst = 1'b1;
        #3;

        // Advance
        set_ex(5, 1, 32'h0000_00F0);
        tick("advance");
        chk("advance.wdata_lit", 64'(mem_wdata), 64'h0000_00F0);

        // Bubble during accumulate, then release
        stall = 6'b001111; hilo_i = 64'h1234_5678_9ABC_DEF0; cnt_i = 2'd1;
        tick("bubble");
        chk("bubble.hilo_lit", hilo_o, 64'h1234_5678_9ABC_DEF0);
        chk("bubble.scnt_lit", 64'(stall_cnt), 64'd1);
        stall = 0;
        tick("bubble_release");

        // Hold keeps mem-side contents
        set_ex(7, 1, 32'h0000_00AA);
        tick("hold_load");
        set_ex(9, 1, 32'h1111_2222);
        stall = 6'b011111; hilo_i = 64'hCAFE_0000_BEEF_0001; cnt_i = 2'd2;
        for (int i = 0; i < 3; i++) tick("hold");
        chk("hold.wdata_lit", 64'(mem_wdata), 64'h0000_00AA);

        // Illegal stall[4] alone behaves as advance
        stall = 6'b010000;
        tick("illegal_adv");

        // Flush beats a bubble request
        stall = 6'b001111; flush = 1'b1; set_ex(3, 1, 32'hDEAD_BEEF);
        tick("flush");
        flush = 1'b0; stall = 0;

        // Async reset mid-accumulate with live data on the MEM side
        set_ex(31, 1, 32'hFFFF_FFFF);
        tick("pre_rst");
        stall = 6'b011111; hilo_i = 64'h0F0F_0F0F_0F0F_0F0F; cnt_i = 2'd3;
        tick("pre_rst_hold");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst = 1'b1;
        stall = 0;
        set_ex(1, 1, 32'h0000_0001);
        tick("post_rst");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stall = 6'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            set_ex(5'($urandom), 1'($urandom), $urandom);
            ex_whilo = 1'($urandom); ex_hi = $urandom;
            hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
            tick("random");
        end

        // Saturation of the bubble counter
        flush = 0; stall = 6'b001000;
        for (int i = 0; i < 65539; i++) begin
            model_edge();
            @(posedge clk);
        end
        #1;
        check_all("saturate");
        chk("saturate.lit", 64'(stall_cnt), 64'hFFFF);
        tick("saturate_more");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
